// File: rtl/addr_bus_arbiter_if.sv
// Address-bus arbiter handshake bundle: requester/memory side (master) and arbiter side (slave).
interface addr_bus_arbiter_if #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] inc;
   logic            mem_ready;
   logic [NREQ-1:0] oe_addr_n;
   logic [NREQ-1:0] cnt;
   logic [NREQ-1:0] ack;
   logic            mem_req;
   logic            busy;
   logic [ID_W-1:0] cur_id;

   modport master (
      output req, inc, mem_ready,
      input  oe_addr_n, cnt, ack, mem_req, busy, cur_id
   );

   modport slave (
      input  req, inc, mem_ready,
      output oe_addr_n, cnt, ack, mem_req, busy, cur_id
   );
endinterface

// File: rtl/addr_bus_arbiter.sv
// Round-robin owner of the shared 16-bit address bus: grants one pointer_reg, handshakes memory, strobes post-increment.
// Optional ADDR_ARB_FIXED_PRIO_EN: index 0 (PC fetch) always wins, the rest rotate among themselves.
module addr_bus_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   addr_bus_arbiter_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] oe_n_q, oe_n_d;
   logic [NREQ-1:0] cnt_q, cnt_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            mem_req_q, mem_req_d;
   logic            busy_q, busy_d;
   logic [ID_W-1:0] cur_id_q, cur_id_d;
   logic [ID_W-1:0] rr_q, rr_d;
   logic            inc_l_q, inc_l_d;

   logic [NREQ-1:0]   rq, rot;
   logic [2*NREQ-1:0] dbl;
   logic [ID_W-1:0]   rr_eff, win, rr_nxt;
   logic [ID_W:0]     koff, sum;
   logic              prio0;

   // Rotate req right by the search start, take the lowest set bit, then map back to an index.
   always_comb begin
      rq     = bus.req;
      rr_eff = rr_q;
      prio0  = 1'b0;
`ifdef ADDR_ARB_FIXED_PRIO_EN
      prio0  = bus.req[0];
      rq[0]  = 1'b0;
      if (rr_q == '0) rr_eff = ID_W'(1);
`endif
      dbl  = {rq, rq};
      rot  = NREQ'(dbl >> rr_eff);
      koff = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (rot[k]) koff = (ID_W+1)'(k);
      end
      sum = {1'b0, rr_eff} + koff;
      if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
      win    = prio0 ? '0 : sum[ID_W-1:0];
      rr_nxt = rr_q;
      if (!prio0) rr_nxt = (win == ID_W'(NREQ-1)) ? '0 : win + ID_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      oe_n_d    = oe_n_q;
      cnt_d     = cnt_q;
      ack_d     = ack_q;
      mem_req_d = mem_req_q;
      busy_d    = busy_q;
      cur_id_d  = cur_id_q;
      rr_d      = rr_q;
      inc_l_d   = inc_l_q;
      case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               state_d   = S_ACCESS;
               oe_n_d    = ~(ONE << win);
               mem_req_d = 1'b1;
               busy_d    = 1'b1;
               cur_id_d  = win;
               inc_l_d   = bus.inc[win];
               rr_d      = rr_nxt;
            end
         end
         S_ACCESS: begin
            if (bus.mem_ready) begin
               state_d   = S_DONE;
               oe_n_d    = '1;
               mem_req_d = 1'b0;
               ack_d     = ONE << cur_id_q;
               cnt_d     = inc_l_q ? (ONE << cur_id_q) : '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ack_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d   = S_IDLE;
            oe_n_d    = '1;
            mem_req_d = 1'b0;
            ack_d     = '0;
            cnt_d     = '0;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         oe_n_q    <= '1;
         cnt_q     <= '0;
         ack_q     <= '0;
         mem_req_q <= 1'b0;
         busy_q    <= 1'b0;
         cur_id_q  <= '0;
         rr_q      <= '0;
         inc_l_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         oe_n_q    <= oe_n_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         mem_req_q <= mem_req_d;
         busy_q    <= busy_d;
         cur_id_q  <= cur_id_d;
         rr_q      <= rr_d;
         inc_l_q   <= inc_l_d;
      end
   end

   assign bus.oe_addr_n = oe_n_q;
   assign bus.cnt       = cnt_q;
   assign bus.ack       = ack_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.busy      = busy_q;
   assign bus.cur_id    = cur_id_q;

endmodule
